// File: rtl/dmem_rdback_wrapper_pkg.sv
// Shared constants and helpers for the data-memory read-back path.
//   DMEM_DATA_W : data RAM word width
//   RF_ADDR_W   : register file index width
//   DELAY_W     : per-load writeback delay field width
//   MAX_DELAY   : largest legal delay (0 = direct, 2 = indirect via sprf)
package dmem_rdback_wrapper_pkg;

    localparam int unsigned DMEM_DATA_W = 16;
    localparam int unsigned RF_ADDR_W   = 5;
    localparam int unsigned DELAY_W     = 2;
    localparam int unsigned MAX_DELAY   = 2;

    // Cycles (ignoring stalls) until an entry sitting in stage `stage` writes back.
    function automatic int cycles_to_retire(input int dly, input int stage);
        return 1 + dly - stage;
    endfunction

    // Cycles (ignoring stalls) from issue to writeback for a new load.
    function automatic int issue_latency(input int dly);
        return 2 + dly;
    endfunction

endpackage

// File: rtl/dmem_rdback_wrapper_rdb_stage.sv
// One read-back pipeline register {valid, dst, delay, data}.
// Loads its input when adv=1, holds otherwise.
// Ports:
//   clk, reset_b          : clock, async active-low reset
//   adv                   : advance enable (global core enable)
//   in_valid/dst/dly/data : entry from the previous stage
//   out_valid/dst/dly/data: registered entry
module dmem_rdback_wrapper_rdb_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RF_AW  = 5,
    parameter int unsigned DLY_W  = 2
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              adv,
    input  logic              in_valid,
    input  logic [RF_AW-1:0]  in_dst,
    input  logic [DLY_W-1:0]  in_dly,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [RF_AW-1:0]  out_dst,
    output logic [DLY_W-1:0]  out_dly,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_q;
    logic [RF_AW-1:0]  dst_q;
    logic [DLY_W-1:0]  dly_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            valid_q <= 1'b0;
            dst_q   <= '0;
            dly_q   <= '0;
            data_q  <= '0;
        end else if (adv) begin
            valid_q <= in_valid;
            dst_q   <= in_dst;
            dly_q   <= in_dly;
            data_q  <= in_data;
        end
    end

    assign out_valid = valid_q;
    assign out_dst   = dst_q;
    assign out_dly   = dly_q;
    assign out_data  = data_q;

endmodule

// File: rtl/dmem_rdback_wrapper.sv
// Data RAM read-back path toward gprf/sprf. Tracks each load issued by the
// decoder, captures the RAM word one cycle after issue, delays it by the
// load's delay field and writes it back on a single port.
// Ports:
//   clk, reset_b          : clock, async active-low reset
//   t_cs                  : global core enable, 0 freezes the pipeline
//   ipt_dec_to_rdb_*      : load issue (active-low strobe, dst register, delay)
//   ipt_dram_to_rdb_data  : RAM read word, valid the cycle after issue
//   opt_rdb_to_rf_*       : writeback strobe, register index, data
//   opt_rdb_hazard        : combinational, an issue now would collide
//   opt_rdb_err           : sticky, a colliding or illegal issue was dropped
module dmem_rdback_wrapper
    import dmem_rdback_wrapper_pkg::*;
#(
    parameter int unsigned DATA_W  = DMEM_DATA_W,
    parameter int unsigned RF_AW   = RF_ADDR_W,
    parameter int unsigned DLY_W   = DELAY_W,
    parameter int unsigned MAX_DLY = MAX_DELAY
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              t_cs,
    input  logic              ipt_dec_to_rdb_en_b,
    input  logic [RF_AW-1:0]  ipt_dec_to_rdb_dst,
    input  logic [DLY_W-1:0]  ipt_dec_to_rdb_delay,
    input  logic [DATA_W-1:0] ipt_dram_to_rdb_data,
    output logic              opt_rdb_to_rf_we,
    output logic [RF_AW-1:0]  opt_rdb_to_rf_addr,
    output logic [DATA_W-1:0] opt_rdb_to_rf_data,
    output logic              opt_rdb_hazard,
    output logic              opt_rdb_err
);

    // S0 plus S1..S(MAX_DLY+1)
    localparam int NS = int'(MAX_DLY) + 2;

    logic              s0_valid_q;
    logic [RF_AW-1:0]  s0_dst_q;
    logic [DLY_W-1:0]  s0_dly_q;
    logic [DATA_W-1:0] skid_q;
    logic              cap_done_q;
    logic              err_q;

    logic [NS-1:0]     st_valid;
    logic [RF_AW-1:0]  st_dst  [NS];
    logic [DLY_W-1:0]  st_dly  [NS];
    logic [DATA_W-1:0] st_data [NS];
    logic [NS-1:0]     retire;

    logic issue, dly_ok, accept, drop, hazard;

    assign issue  = !ipt_dec_to_rdb_en_b;
    assign dly_ok = 32'(ipt_dec_to_rdb_delay) <= MAX_DLY;
    assign accept = t_cs && issue && !hazard && dly_ok;
    assign drop   = t_cs && issue && (hazard || !dly_ok);

    // A new load collides when it would retire in the same cycle as an in-flight one.
    always_comb begin
        hazard = 1'b0;
        if (issue) begin
            for (int k = 0; k < NS; k++) begin
                if (st_valid[k] &&
                    cycles_to_retire(int'(st_dly[k]), k) ==
                    issue_latency(int'(ipt_dec_to_rdb_delay))) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            s0_valid_q <= 1'b0;
            s0_dst_q   <= '0;
            s0_dly_q   <= '0;
            skid_q     <= '0;
            cap_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // RAM word is only present in the first cycle S0 holds the entry, so it is
            // captured regardless of t_cs and then held until the entry advances.
            if (s0_valid_q && !cap_done_q) begin
                skid_q <= ipt_dram_to_rdb_data;
            end
            if (t_cs) begin
                s0_valid_q <= accept;
                cap_done_q <= 1'b0;
                if (accept) begin
                    s0_dst_q <= ipt_dec_to_rdb_dst;
                    s0_dly_q <= ipt_dec_to_rdb_delay;
                end
            end else if (s0_valid_q) begin
                cap_done_q <= 1'b1;
            end
            if (drop) begin
                err_q <= 1'b1;
            end
        end
    end

    assign st_valid[0] = s0_valid_q;
    assign st_dst[0]   = s0_dst_q;
    assign st_dly[0]   = s0_dly_q;
    assign st_data[0]  = cap_done_q ? skid_q : ipt_dram_to_rdb_data;
    assign retire[0]   = 1'b0;

    for (genvar k = 1; k < NS; k++) begin : g_stage
        // Stage k holds entries that retire here when delay == k-1.
        assign retire[k] = st_valid[k] && (st_dly[k] == DLY_W'(k - 1));

        dmem_rdback_wrapper_rdb_stage #(
            .DATA_W (DATA_W),
            .RF_AW  (RF_AW),
            .DLY_W  (DLY_W)
        ) u_stage (
            .clk       (clk),
            .reset_b   (reset_b),
            .adv       (t_cs),
            .in_valid  (st_valid[k-1] && !retire[k-1]),
            .in_dst    (st_dst[k-1]),
            .in_dly    (st_dly[k-1]),
            .in_data   (st_data[k-1]),
            .out_valid (st_valid[k]),
            .out_dst   (st_dst[k]),
            .out_dly   (st_dly[k]),
            .out_data  (st_data[k])
        );
    end

    always_comb begin
        opt_rdb_to_rf_we   = 1'b0;
        opt_rdb_to_rf_addr = '0;
        opt_rdb_to_rf_data = '0;
        for (int k = 1; k < NS; k++) begin
            if (t_cs && retire[k]) begin
                opt_rdb_to_rf_we   = 1'b1;
                opt_rdb_to_rf_addr = st_dst[k];
                opt_rdb_to_rf_data = st_data[k];
            end
        end
    end

    assign opt_rdb_hazard = hazard;
    assign opt_rdb_err    = err_q;

endmodule

// File: doc/dmem_rdback_wrapper.md
Name: dmem_rdback_wrapper

Overview:
- Return path from data RAM to the register files. It is the read-data counterpart of the data-memory address/rw wrapper.
- Tracks each load issued by ins_decoder and captures the RAM read word. Delays the word by the per-instruction delay (0 = direct, 2 = indirect via sprf).
- Drives one registered-order writeback port toward gprf/sprf.
- Freezes under the global enable t_cs without losing RAM data.

Parameters:
- DATA_W, 16, data RAM word width (`DMEMDATAW in define.v).
- RF_AW, 5, destination register index width.
- DLY_W, 2, delay field width (`DLY_W).
- MAX_DLY, 2, largest legal delay; sets pipeline depth to MAX_DLY+2 stages (S0..S(MAX_DLY+1)).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset_b  in  1  reset, asynchronous, active-low.
- t_cs  in  1  global core enable; 0 = stall/freeze.
- ipt_dec_to_rdb_en_b  in  1  active-low load issue strobe.
- ipt_dec_to_rdb_dst  in  RF_AW  destination register of the load.
- ipt_dec_to_rdb_delay  in  DLY_W  extra writeback delay.
- ipt_dram_to_rdb_data  in  DATA_W  RAM read data; valid in the cycle after the address cycle.
- opt_rdb_to_rf_we  out  1  writeback strobe, one cycle per load.
- opt_rdb_to_rf_addr  out  RF_AW  writeback register index.
- opt_rdb_to_rf_data  out  DATA_W  writeback data.
- opt_rdb_hazard  out  1  combinational: an issue this cycle would collide with an in-flight load.
- opt_rdb_err  out  1  sticky: a colliding or illegal issue was dropped.

Behaviour:
- Reset (async, any time, including mid-flight):
  - All stage valid bits, capture flags and err clear. Data/dst registers go to 0.
  - Outputs we=0, addr=0, data=0, hazard=0, err=0. In-flight loads are discarded with no writeback.
- Issue acceptance:
  - A load is accepted at the edge ending cycle N when t_cs=1, en_b=0, hazard=0 and delay<=MAX_DLY.
  - The accepted load loads S0 {valid, dst, delay}; S0 is valid in cycle N+1.
  - If hazard=1 or delay>MAX_DLY, the issue is dropped and err sets to 1 at that edge.
  - err clears only on reset.
  - Issue with t_cs=0 is ignored and does not set err.
- Data capture:
  - RAM data for the S0 entry is present in the first cycle S0 holds that entry.
  - At that edge, data is sampled into the S0 skid register unconditionally, even when t_cs=0, and cap_done is set.
  - While stalled, the skid value is held and the RAM is not resampled.
- Advance:
  - When t_cs=1, every Sk moves to S(k+1).
  - S0→S1 takes the skid value if cap_done=1, else ipt_dram_to_rdb_data directly.
  - When t_cs=0, all stages hold.
- Writeback:
  - An entry retires from stage S(1+delay).
  - we = t_cs AND valid(Sk) AND (delay(Sk)==k-1). addr and data come from that stage.
  - When we=0, addr and data are 0.
  - The retiring entry is not propagated further.
  - No stalls: writeback in cycle N+2+delay. Each stall cycle in flight adds exactly one cycle.
- Hazard:
  - An entry at Sk with delay e retires in 1+e-k cycles; a new issue with delay d retires in 2+d cycles.
  - hazard = OR over valid Sk of (e-k == d+1). Evaluated with en_b=0 only; otherwise hazard=0.
  - Guarantees at most one writeback per cycle.
- Back-to-back loads with equal delay:
  - Fully pipelined, one issue per cycle, with writebacks on consecutive cycles.
- Widths: delay is compared unsigned; there is no arithmetic on data.

Decomposition:
- define.v (shared): `DMEMDATAW, `DLY_W, `RFADDRW, and the MAX_DLY constant.
- One natural sub-module: rdb_stage, a single pipeline register {valid, dst, delay, data} with hold-on-stall.
- The top instantiates MAX_DLY+1 rdb_stage instances after the S0/skid logic.

Test Plan:
- Reset then idle: we=0, addr=0, data=0, hazard=0, err=0 for 10 cycles with random RAM data.
- Direct load:
  - Stimulus: issue dst=3, delay=0 at cycle 5; RAM data 0xA5A5 in cycle 6.
  - Required: cycle 7 shows we=1, addr=3, data=0xA5A5; we=0 in all other cycles.
- Indirect load:
  - Stimulus: issue dst=7, delay=2 at cycle 5; RAM data 0x1234 in cycle 6.
  - Required: writeback in cycle 9 with addr=7, data=0x1234.
- Stall during capture:
  - Stimulus: issue dst=2, delay=0 at cycle 5; RAM 0xBEEF in cycle 6, 0x0000 afterwards; t_cs=0 in cycles 6-7.
  - Required: writeback in cycle 9 with data=0xBEEF.
- Collision and pipelining:
  - Collision: delay=2 at cycle 5, then delay=1 at cycle 6 → hazard=1 in cycle 6, second load dropped, err=1, single writeback at cycle 9.
  - Pipelining: delay=0 loads at cycles 10, 11, 12 → writebacks at 12, 13, 14 in order.
- Reset mid-flight:
  - Stimulus: issue delay=2 at cycle 5; reset_b pulsed low in cycle 7.
  - Required: no writeback ever, err=0.
